jacobi_solver_nxn: RTL and testbench

//  Parametrised NxN iterative Jacobi linear-system solver, signed fixed-point Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS.

---
 rtl/jacobi_solver_nxn.sv | 257 +++++++++++++++++++++++++
 tb/tb_jacobi_solver_nxn.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/jacobi_solver_nxn.sv
// jacobi_solver_nxn
//   Iterative Jacobi solver for A*x = b, signed fixed point with FRAC_BITS
//   fractional bits. One shared multiplier accumulates a row's off-diagonal
//   products (one per cycle). A serial restoring divider then forms
//   x_new[i] = (b[i]-sum) / A[i][i]. The solve ends on tolerance convergence
//   or after MAX_ITER iterations.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, tol          begin solve (IDLE/DONE only), tolerance latched at start
//   a_wen/a_addr/a_data A write port, row-major, ignored while busy
//   b_wen/b_addr/b_data b write port, ignored while busy
//   x_addr/x_data       combinational readback of committed x
//   busy, done          solve in progress / finished
//   converged           1 = tolerance exit, 0 = iteration-ceiling exit
//   div_zero            a zero diagonal was seen during this solve
//   iter_count          iterations completed
//
// state    | meaning
// S_IDLE   | waiting for start
// S_INIT   | clear x, flags, counters
// S_MAC    | accumulate A[i][j]*x[j], j != i
// S_DIV    | setup, restoring divide, sign/saturate, store x_new[i]
// S_CHECK  | compare x_new against x with tolerance
// S_COMMIT | x <= x_new, decide next iteration or DONE
// S_DONE   | results held for readback
module jacobi_solver_nxn #(
  parameter int N          = 3,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int MAX_ITER   = 40,
  parameter int A_AW       = $clog2(N*N),
  parameter int X_AW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tol,
  input  logic                  a_wen,
  input  logic [A_AW-1:0]       a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_wen,
  input  logic [X_AW-1:0]       b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic [X_AW-1:0]       x_addr,
  output logic [DATA_WIDTH-1:0] x_data,
  output logic                  busy,
  output logic                  done,
  output logic                  converged,
  output logic                  div_zero,
  output logic [7:0]            iter_count
);

  localparam int DW    = DATA_WIDTH;
  localparam int FB    = FRAC_BITS;
  localparam int ACC_W = 2*DW + X_AW;
  localparam int NUM_W = ACC_W + 1;
  localparam int QW    = DW + FB;
  localparam int CW    = $clog2(QW + 2);

  localparam logic [QW-1:0] Q_POS_MAX = {{(QW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic [QW-1:0] Q_NEG_MAX = {{(QW-DW){1'b0}}, 1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] X_POS_SAT = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] X_NEG_SAT = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_MAC, S_DIV, S_CHECK, S_COMMIT, S_DONE
  } state_t;

  state_t              r_state;
  logic [DW-1:0]       r_a  [N*N];
  logic [DW-1:0]       r_b  [N];
  logic [DW-1:0]       r_x  [N];
  logic [DW-1:0]       r_xn [N];
  logic [X_AW-1:0]     r_i, r_j;
  logic signed [ACC_W-1:0] r_acc;
  logic [CW-1:0]       r_cnt;
  logic [DW-1:0]       r_rem;
  logic [QW-1:0]       r_dvd, r_q;
  logic                r_ovf, r_neg, r_dz;
  logic [DW-1:0]       r_tol;
  logic                r_conv;
  logic                r_busy, r_done, r_converged, r_div_zero;
  logic [7:0]          r_iter;

  logic [A_AW-1:0]         w_aij_addr, w_aii_addr;
  logic [DW-1:0]           w_aij, w_aii, w_xj;
  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [NUM_W-1:0] w_num;
  logic [NUM_W-1:0]        w_num_mag, w_hi;
  logic [DW-1:0]           w_div;
  logic                    w_ovf0;
  logic [DW:0]             w_sh;
  logic                    w_ge;
  logic [DW-1:0]           w_sub;
  logic [DW-1:0]           w_res;
  logic                    w_conv;

  assign busy       = r_busy;
  assign done       = r_done;
  assign converged  = r_converged;
  assign div_zero   = r_div_zero;
  assign iter_count = r_iter;

  assign x_data = ({1'b0, x_addr} < (X_AW+1)'(N)) ? r_x[x_addr] : '0;

  assign w_aij_addr = A_AW'(int'(r_i) * N + int'(r_j));
  assign w_aii_addr = A_AW'(int'(r_i) * (N + 1));
  assign w_aij      = r_a[w_aij_addr];
  assign w_aii      = r_a[w_aii_addr];
  assign w_xj       = r_x[r_j];
  assign w_prod     = $signed(w_aij) * $signed(w_xj);
  assign w_prod_ext = ACC_W'(w_prod >>> FB);

  // Divider works on magnitudes; sign is re-applied after the quotient is done.
  assign w_num     = {{(NUM_W-DW){r_b[r_i][DW-1]}}, r_b[r_i]} - {r_acc[ACC_W-1], r_acc};
  assign w_num_mag = w_num[NUM_W-1] ? NUM_W'(-w_num) : NUM_W'(w_num);
  assign w_div     = w_aii[DW-1] ? (~w_aii + 1'b1) : w_aii;
  // Dividend is |num|<<FB. Its bits above the QW quotient positions start the
  // remainder; if they already reach the divisor the quotient cannot fit.
  assign w_hi      = w_num_mag >> DW;
  assign w_ovf0    = (w_hi >= {{(NUM_W-DW){1'b0}}, w_div});

  assign w_sh  = {r_rem, r_dvd[QW-1]};
  assign w_ge  = (w_sh >= {1'b0, w_div});
  assign w_sub = w_sh[DW-1:0] - w_div;

  always_comb begin
    w_res = '0;
    if (r_dz)
      w_res = '0;
    else if (!r_neg)
      w_res = (r_ovf || r_q > Q_POS_MAX) ? X_POS_SAT : r_q[DW-1:0];
    else
      w_res = (r_ovf || r_q > Q_NEG_MAX) ? X_NEG_SAT : (~r_q[DW-1:0] + 1'b1);
  end

  always_comb begin
    logic signed [DW:0] d;
    logic [DW:0]        m;
    w_conv = 1'b1;
    for (int k = 0; k < N; k++) begin
      d = {r_xn[k][DW-1], r_xn[k]} - {r_x[k][DW-1], r_x[k]};
      m = d[DW] ? (~d + 1'b1) : d;
      if (m > {1'b0, r_tol}) w_conv = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_converged <= 1'b0;
      r_div_zero  <= 1'b0;
      r_iter      <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_q         <= '0;
      r_ovf       <= 1'b0;
      r_neg       <= 1'b0;
      r_dz        <= 1'b0;
      r_tol       <= '0;
      r_conv      <= 1'b0;
      for (int k = 0; k < N; k++) begin
        r_x[k]  <= '0;
        r_xn[k] <= '0;
      end
    end else begin
      if (!r_busy) begin
        if (a_wen && ({1'b0, a_addr} < (A_AW+1)'(N*N))) r_a[a_addr] <= a_data;
        if (b_wen && ({1'b0, b_addr} < (X_AW+1)'(N)))   r_b[b_addr] <= b_data;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_INIT;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_converged <= 1'b0;
            r_div_zero  <= 1'b0;
            r_iter      <= '0;
            r_tol       <= tol;
          end
        end
        S_INIT: begin
          for (int k = 0; k < N; k++) r_x[k] <= '0;
          r_i     <= '0;
          r_j     <= '0;
          r_acc   <= '0;
          r_state <= S_MAC;
        end
        S_MAC: begin
          if (r_j != r_i) r_acc <= r_acc + w_prod_ext;
          if (r_j == X_AW'(N-1)) begin
            r_j     <= '0;
            r_cnt   <= CW'(QW + 1);
            r_state <= S_DIV;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        S_DIV: begin
          if (r_cnt == CW'(QW + 1)) begin
            r_rem <= w_ovf0 ? '0 : w_hi[DW-1:0];
            r_dvd <= {w_num_mag[DW-1:0], {FB{1'b0}}};
            r_q   <= '0;
            r_ovf <= w_ovf0;
            r_neg <= w_num[NUM_W-1] ^ w_aii[DW-1];
            r_dz  <= (w_div == '0);
          end else if (r_cnt != '0) begin
            r_rem <= w_ge ? w_sub : w_sh[DW-1:0];
            r_q   <= {r_q[QW-2:0], w_ge};
            r_dvd <= {r_dvd[QW-2:0], 1'b0};
          end else begin
            r_xn[r_i] <= w_res;
            if (r_dz) r_div_zero <= 1'b1;
            r_acc <= '0;
            if (r_i == X_AW'(N-1)) begin
              r_state <= S_CHECK;
            end else begin
              r_i     <= r_i + 1'b1;
              r_state <= S_MAC;
            end
          end
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_CHECK: begin
          r_conv  <= w_conv;
          r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          for (int k = 0; k < N; k++) r_x[k] <= r_xn[k];
          r_iter <= r_iter + 8'd1;
          r_i    <= '0;
          r_j    <= '0;
          r_acc  <= '0;
          if (r_conv || (r_iter + 8'd1 == 8'(MAX_ITER))) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_converged <= r_conv;
          end else begin
            r_state <= S_MAC;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jacobi_solver_nxn.sv
// Directed bench for jacobi_solver_nxn (N=3, Q8.8) plus a MAX_ITER=3 instance.
module tb_jacobi_solver_nxn;

  logic        clk = 1'b0;
  logic        rst, start, start3, a_wen, b_wen;
  logic [15:0] tol, tol3, a_data, b_data;
  logic [3:0]  a_addr;
  logic [1:0]  b_addr, x_addr;
  logic [15:0] x_data, x_data3;
  logic        busy, done, conv, dz;
  logic        busy3, done3, conv3, dz3;
  logic [7:0]  iter, iter3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  jacobi_solver_nxn #(.N(3), .DATA_WIDTH(16), .FRAC_BITS(8), .MAX_ITER(40)) u_dut (
    .clk(clk), .rst(rst), .start(start), .tol(tol),
    .a_wen(a_wen), .a_addr(a_addr), .a_data(a_data),
    .b_wen(b_wen), .b_addr(b_addr), .b_data(b_data),
    .x_addr(x_addr), .x_data(x_data),
    .busy(busy), .done(done), .converged(conv), .div_zero(dz), .iter_count(iter)
  );

  jacobi_solver_nxn #(.N(3), .DATA_WIDTH(16), .FRAC_BITS(8), .MAX_ITER(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .tol(tol3),
    .a_wen(a_wen), .a_addr(a_addr), .a_data(a_data),
    .b_wen(b_wen), .b_addr(b_addr), .b_data(b_data),
    .x_addr(x_addr), .x_data(x_data3),
    .busy(busy3), .done(done3), .converged(conv3), .div_zero(dz3), .iter_count(iter3)
  );

  logic [15:0] a_c1  [9] = '{16'h0400, 16'h0100, 16'h0100,
                             16'h0100, 16'h0300, 16'h0000,
                             16'h0100, 16'h0000, 16'h0200};
  logic [15:0] b_c1  [3] = '{16'h0500, 16'h0700, 16'hFF00};
  logic [15:0] a_id  [9] = '{16'h0100, 16'h0000, 16'h0000,
                             16'h0000, 16'h0100, 16'h0000,
                             16'h0000, 16'h0000, 16'h0100};
  logic [15:0] b_id  [3] = '{16'h0300, 16'hFE00, 16'h0080};
  logic [15:0] a_sat [9] = '{16'h0001, 16'h0000, 16'h0000,
                             16'h0000, 16'h0001, 16'h0000,
                             16'h0000, 16'h0000, 16'h0001};
  logic [15:0] b_sat [3] = '{16'h7F00, 16'h8100, 16'h0000};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input int addr, input logic [15:0] d);
    a_wen = 1'b1; a_addr = 4'(addr); a_data = d;
    tick;
    a_wen = 1'b0;
  endtask

  task automatic wr_b(input int addr, input logic [15:0] d);
    b_wen = 1'b1; b_addr = 2'(addr); b_data = d;
    tick;
    b_wen = 1'b0;
  endtask

  task automatic load(input logic [15:0] a[9], input logic [15:0] b[3]);
    for (int k = 0; k < 9; k++) wr_a(k, a[k]);
    for (int k = 0; k < 3; k++) wr_b(k, b[k]);
  endtask

  task automatic pulse_start(input logic s1, input logic s3);
    start = s1; start3 = s3;
    tick;
    start = 1'b0; start3 = 1'b0;
  endtask

  // Cycles from the accepted-start edge until done is seen, bounded.
  task automatic wait_done(input string tag, output int cycles);
    cycles = 0;
    while (!done && cycles < 6000) begin
      tick;
      cycles++;
    end
    check_eq({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic read_x(input int k, output logic [15:0] v);
    x_addr = 2'(k);
    #1;
    v = x_data;
  endtask

  function automatic logic near(input logic [15:0] v, input logic [15:0] e);
    int d;
    d = int'($signed(v)) - int'($signed(e));
    return (d >= -2) && (d <= 2);
  endfunction

  task automatic check_case1_x(input string tag);
    logic [15:0] v;
    read_x(0, v); check_eq({tag, "_x0_near"}, 32'(near(v, 16'h0100)), 32'd1);
    read_x(1, v); check_eq({tag, "_x1_near"}, 32'(near(v, 16'h0200)), 32'd1);
    read_x(2, v); check_eq({tag, "_x2_near"}, 32'(near(v, 16'hFF00)), 32'd1);
  endtask

  initial begin
    logic [15:0] v;
    int cyc;

    rst = 1'b1; start = 1'b0; start3 = 1'b0; tol = '0; tol3 = '0;
    a_wen = 1'b0; b_wen = 1'b0; a_addr = '0; b_addr = '0;
    a_data = '0; b_data = '0; x_addr = '0;
    repeat (3) tick;
    rst = 1'b0;
    tick;

    // reset state
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_conv", 32'(conv), 32'd0);
    check_eq("rst_dz",   32'(dz),   32'd0);
    check_eq("rst_iter", 32'(iter), 32'd0);
    for (int k = 0; k < 3; k++) begin
      read_x(k, v);
      check_eq($sformatf("rst_x%0d", k), 32'(v), 32'd0);
    end

    // identity: x == b after 2 iterations, exact latency
    load(a_id, b_id);
    tol = 16'h0000;
    pulse_start(1'b1, 1'b0);
    check_eq("id_busy", 32'(busy), 32'd1);
    wait_done("id", cyc);
    check_eq("id_latency", 32'(cyc), 32'd179);
    check_eq("id_conv", 32'(conv), 32'd1);
    check_eq("id_iter", 32'(iter), 32'd2);
    check_eq("id_busy_end", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      read_x(k, v);
      check_eq($sformatf("id_x%0d", k), 32'(v), 32'(b_id[k]));
    end

    // saturation
    load(a_sat, b_sat);
    pulse_start(1'b1, 1'b0);
    wait_done("sat", cyc);
    read_x(0, v); check_eq("sat_x0", 32'(v), 32'h7FFF);
    read_x(1, v); check_eq("sat_x1", 32'(v), 32'h8000);
    read_x(2, v); check_eq("sat_x2", 32'(v), 32'h0000);

    // case 1 on both instances; MAX_ITER=3 instance with tol=0
    load(a_c1, b_c1);
    tol = 16'h0002; tol3 = 16'h0000;
    pulse_start(1'b1, 1'b1);
    wait_done("c1", cyc);
    check_eq("c1_conv", 32'(conv), 32'd1);
    check_eq("c1_iter_lt40", 32'(iter < 8'd40), 32'd1);
    check_eq("c1_dz", 32'(dz), 32'd0);
    check_case1_x("c1");
    check_eq("mi3_done", 32'(done3), 32'd1);
    check_eq("mi3_conv", 32'(conv3), 32'd0);
    check_eq("mi3_iter", 32'(iter3), 32'd3);

    // writes and start during busy are ignored
    pulse_start(1'b1, 1'b0);
    repeat (10) tick;
    wr_a(0, 16'h7000);
    wr_b(0, 16'h0000);
    pulse_start(1'b1, 1'b0);
    check_eq("grd_busy", 32'(busy), 32'd1);
    wait_done("grd", cyc);
    check_eq("grd_conv", 32'(conv), 32'd1);
    check_case1_x("grd");

    // zero pivot on row 1
    wr_a(4, 16'h0000);
    pulse_start(1'b1, 1'b0);
    wait_done("dz", cyc);
    check_eq("dz_flag", 32'(dz), 32'd1);
    read_x(1, v); check_eq("dz_x1", 32'(v), 32'd0);
    wr_a(4, 16'h0300);
    pulse_start(1'b1, 1'b0);
    wait_done("dz2", cyc);
    check_eq("dz2_flag", 32'(dz), 32'd0);
    check_case1_x("dz2");

    // reset mid-MAC of the second iteration
    pulse_start(1'b1, 1'b0);
    repeat (91) tick;
    check_eq("mid_iter", 32'(iter), 32'd1);
    check_eq("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_done", 32'(done), 32'd0);
    check_eq("mrst_iter", 32'(iter), 32'd0);
    for (int k = 0; k < 3; k++) begin
      read_x(k, v);
      check_eq($sformatf("mrst_x%0d", k), 32'(v), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
